// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default constants for the Avalon-MM memory arbiter.
//   arb_state_e : arbiter FSM states
//   req_id_t    : requester index, sized for the default requester count
//   *_DEF       : default parameter values used by mem_arbiter
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int NUM_REQ_DEF     = 3;
    localparam int MAX_PENDING_DEF = 8;
    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int REQ_ID_W        = (NUM_REQ_DEF > 1) ? $clog2(NUM_REQ_DEF) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

    typedef logic [REQ_ID_W-1:0] req_id_t;

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// -----------------------------------------------------------------------------
// mem_arb_tag_fifo
// Synchronous FIFO of requester ids, one entry per outstanding read.
// Ports:
//   clock, reset_n  : clock, asynchronous active-low reset
//   push_i/push_data_i : enqueue an id
//   pop_i / head_o  : dequeue; head_o is the oldest id (valid when !empty_o)
//   full_o, empty_o : occupancy flags
//   count_o         : number of stored entries (0..DEPTH)
// Push and pop in the same cycle are both honoured; a push while full is
// accepted only if a pop frees the slot in that same cycle.
// DEPTH must be a power of 2 (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module mem_arb_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int  DEPTH  = MAX_PENDING_DEF,
    parameter type elem_t = req_id_t
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  elem_t                  push_data_i,
    input  logic                   pop_i,
    output elem_t                  head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    elem_t         mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: count_q gates every read of it.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one Avalon-MM master between NUM_REQ requesters with round-robin
// arbitration over whole commands. Read commands push the issuing requester's
// id onto a tag FIFO; each m_readdatavalid beat pops it and strobes that
// requester's req_readdatavalid.
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   req_*                 : per-requester Avalon slave side (packed per port)
//   req_readdata          : read data broadcast to all requesters
//   req_readdatavalid     : one-hot read return strobe
//   m_*                   : shared Avalon master side
//   rsp_error             : sticky, set by a read beat with no pending tag
// Optional (MEM_ARB_STATS_EN defined):
//   stats_clear           : zero all grant counters next cycle
//   grant_count           : per-requester accepted-command counters
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int MAX_PENDING = MAX_PENDING_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_address,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_writedata,
    input  logic [NUM_REQ-1:0]              req_read,
    input  logic [NUM_REQ-1:0]              req_write,
    output logic [NUM_REQ-1:0]              req_waitrequest,
    output logic [DATA_W-1:0]               req_readdata,
    output logic [NUM_REQ-1:0]              req_readdatavalid,
    output logic [ADDR_W-1:0]               m_address,
    output logic [DATA_W-1:0]               m_writedata,
    output logic                            m_read,
    output logic                            m_write,
    input  logic                            m_waitrequest,
    input  logic [DATA_W-1:0]               m_readdata,
    input  logic                            m_readdatavalid,
    output logic                            rsp_error
`ifdef MEM_ARB_STATS_EN
   ,input  logic                            stats_clear,
    output logic [NUM_REQ-1:0][31:0]        grant_count
`endif
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_PENDING) + 1;

    typedef logic [ID_W-1:0] id_t;

    arb_state_e         state_q, state_d;
    id_t                owner_q, owner_d;
    id_t                rr_ptr_q, rr_ptr_d;
    logic               rsp_error_q, rsp_error_d;

    logic [NUM_REQ-1:0] eligible;
    logic               pick_vld;
    id_t                pick;
    logic               accept;
    logic               read_room;

    logic               tag_push, tag_pop, tag_full, tag_empty;
    id_t                tag_head;
    logic [CNT_W-1:0]   tag_count;

    // Reads need a free tag slot; writes never wait on the FIFO.
    assign read_room = (tag_count < CNT_W'(MAX_PENDING));

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
        assign eligible[i] = req_write[i] | (req_read[i] & read_room);
    end

    // First eligible index at or after rr_ptr_q, wrapping. Scanning from the
    // far end lets the nearest hit overwrite earlier ones.
    always_comb begin
        logic [ID_W:0] s;
        id_t           idx;
        s        = '0;
        idx      = '0;
        pick_vld = 1'b0;
        pick     = rr_ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            s = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (s >= (ID_W+1)'(NUM_REQ)) s = s - (ID_W+1)'(NUM_REQ);
            idx = s[ID_W-1:0];
            if (eligible[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        rr_ptr_d        = rr_ptr_q;
        accept          = 1'b0;
        m_read          = 1'b0;
        m_write         = 1'b0;
        m_address       = req_address[owner_q];
        m_writedata     = req_writedata[owner_q];
        req_waitrequest = '1;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d = pick;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Write wins if a requester illegally raises both.
                m_write = req_write[owner_q];
                m_read  = req_read[owner_q] & ~req_write[owner_q];
                req_waitrequest[owner_q] = m_waitrequest;
                if (!m_waitrequest) begin
                    accept   = 1'b1;
                    state_d  = IDLE;
                    rr_ptr_d = (owner_q == id_t'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tag_push = accept & m_read & (~tag_full | tag_pop);
    assign tag_pop  = m_readdatavalid & ~tag_empty;

    mem_arb_tag_fifo #(
        .DEPTH  (MAX_PENDING),
        .elem_t (id_t)
    ) u_tag_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .push_i      (tag_push),
        .push_data_i (owner_q),
        .pop_i       (tag_pop),
        .head_o      (tag_head),
        .full_o      (tag_full),
        .empty_o     (tag_empty),
        .count_o     (tag_count)
    );

    always_comb begin
        req_readdatavalid = '0;
        if (tag_pop) req_readdatavalid[tag_head] = 1'b1;
    end

    assign req_readdata = m_readdata;
    assign rsp_error_d  = rsp_error_q | (m_readdatavalid & tag_empty);
    assign rsp_error    = rsp_error_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_error_q <= rsp_error_d;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] grant_cnt_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n)
                grant_cnt_q[i] <= '0;
            else if (stats_clear)
                grant_cnt_q[i] <= '0;
            else if (accept && owner_q == id_t'(i))
                grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
        end
    end

    assign grant_count = grant_cnt_q;
`endif

endmodule
